// File: rtl/spi_ip_irq_pkg.sv
// Shared constants for the SPI IP event/interrupt controller.
package spi_ip_irq_pkg;

   localparam int unsigned ADDR_W = 2;

   localparam logic [ADDR_W-1:0] ADDR_PENDING  = ADDR_W'(0);
   localparam logic [ADDR_W-1:0] ADDR_ENABLE   = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] ADDR_OVERFLOW = ADDR_W'(2);
   localparam logic [ADDR_W-1:0] ADDR_MASKED   = ADDR_W'(3);

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } pulse_state_e;

   // Holdoff counter width; a zero holdoff still needs a 1-bit vector.
   function automatic int unsigned cnt_width(input int unsigned holdoff);
      return (holdoff == 0) ? 1 : $clog2(holdoff + 1);
   endfunction

endpackage

// File: rtl/spi_ip_irq_pulse_gen.sv
// Rate-limited interrupt pulse generator: one-cycle pulses with a holdoff
// window, coalescing triggers seen during the window into one deferred pulse.
module spi_ip_irq_pulse_gen
   import spi_ip_irq_pkg::*;
#(
   parameter int unsigned PARAM_HOLDOFF = 8
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_trig,
   output logic o_irq
);

   localparam int unsigned            CNT_W     = cnt_width(PARAM_HOLDOFF);
   localparam logic [CNT_W-1:0]       HOLD_LOAD = CNT_W'(PARAM_HOLDOFF);

   pulse_state_e     r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_deferred;
   logic             r_irq;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_deferred <= 1'b0;
         r_irq      <= 1'b0;
      end else begin
         r_irq <= 1'b0;
         case (r_state)
            IDLE: begin
               if (i_trig) begin
                  r_irq <= 1'b1;
                  if (PARAM_HOLDOFF != 0) begin
                     r_cnt   <= HOLD_LOAD;
                     r_state <= HOLD;
                  end
               end
            end
            HOLD: begin
               // Expiry cycle: either fire the coalesced pulse and restart the window, or go idle.
               if (r_cnt <= CNT_W'(1)) begin
                  if (r_deferred || i_trig) begin
                     r_irq      <= 1'b1;
                     r_deferred <= 1'b0;
                     r_cnt      <= HOLD_LOAD;
                  end else begin
                     r_cnt   <= '0;
                     r_state <= IDLE;
                  end
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
                  if (i_trig) begin
                     r_deferred <= 1'b1;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_irq = r_irq;

endmodule

// File: rtl/spi_ip_irq_ctrl.sv
// Event collector: sticky pending/overflow bits, enable mask, register
// readback with W1C, and a level or rate-limited pulse interrupt.
module spi_ip_irq_ctrl
   import spi_ip_irq_pkg::*;
#(
   parameter int unsigned PARAM_NUM_SRC  = 4,
   parameter string       PARAM_IRQ_MODE = "LEVEL",
   parameter int unsigned PARAM_HOLDOFF  = 8
) (
   input  logic                     ic_clk_i,
   input  logic                     ic_rst_n_i,
   input  logic [PARAM_NUM_SRC-1:0] ic_event_i,
   input  logic                     ic_wr_en_i,
   input  logic                     ic_rd_en_i,
   input  logic [ADDR_W-1:0]        ic_addr_i,
   input  logic [PARAM_NUM_SRC-1:0] ic_wdata_i,
   output logic [PARAM_NUM_SRC-1:0] ic_rdata_o,
   output logic                     ic_rvalid_o,
   output logic                     ic_irq_o,
   output logic                     ic_overflow_o
);

   localparam int unsigned N = PARAM_NUM_SRC;

   logic [N-1:0] r_pending;
   logic [N-1:0] r_enable;
   logic [N-1:0] r_overflow;
   logic [N-1:0] r_rdata;
   logic         r_rvalid;
   logic         r_ovf_any;

   logic [N-1:0] w_pend_clr;
   logic [N-1:0] w_ovf_clr;
   logic [N-1:0] w_pend_next;
   logic [N-1:0] w_ovf_next;
   logic [N-1:0] w_en_next;
   logic [N-1:0] w_masked_next;
   logic [N-1:0] w_rd_mux;
   logic         w_irq;

   assign w_pend_clr = (ic_wr_en_i && ic_addr_i == ADDR_PENDING)  ? ic_wdata_i : '0;
   assign w_ovf_clr  = (ic_wr_en_i && ic_addr_i == ADDR_OVERFLOW) ? ic_wdata_i : '0;
   assign w_en_next  = (ic_wr_en_i && ic_addr_i == ADDR_ENABLE)   ? ic_wdata_i : r_enable;

   // Set beats clear; overflow only when an event hits a pending bit that survives this cycle.
   assign w_pend_next   = (r_pending & ~w_pend_clr) | ic_event_i;
   assign w_ovf_next    = (r_overflow & ~w_ovf_clr) | (ic_event_i & r_pending & ~w_pend_clr);
   assign w_masked_next = w_pend_next & w_en_next;

   always_comb begin
      w_rd_mux = '0;
      case (ic_addr_i)
         ADDR_PENDING:  w_rd_mux = r_pending;
         ADDR_ENABLE:   w_rd_mux = r_enable;
         ADDR_OVERFLOW: w_rd_mux = r_overflow;
         ADDR_MASKED:   w_rd_mux = r_pending & r_enable;
         default:       w_rd_mux = '0;
      endcase
   end

   always_ff @(posedge ic_clk_i or negedge ic_rst_n_i) begin
      if (!ic_rst_n_i) begin
         r_pending  <= '0;
         r_enable   <= '0;
         r_overflow <= '0;
         r_rdata    <= '0;
         r_rvalid   <= 1'b0;
         r_ovf_any  <= 1'b0;
      end else begin
         r_pending  <= w_pend_next;
         r_enable   <= w_en_next;
         r_overflow <= w_ovf_next;
         r_rvalid   <= ic_rd_en_i;
         r_ovf_any  <= |w_ovf_next;
         if (ic_rd_en_i) begin
            r_rdata <= w_rd_mux;
         end
      end
   end

   if (PARAM_IRQ_MODE == "PULSE") begin : g_pulse
      // A trigger is any masked bit going 0->1, from either a new event or an enable write.
      logic w_trig;
      assign w_trig = |(w_masked_next & ~(r_pending & r_enable));

      spi_ip_irq_pulse_gen #(
         .PARAM_HOLDOFF (PARAM_HOLDOFF)
      ) u_pulse_gen (
         .i_clk   (ic_clk_i),
         .i_rst_n (ic_rst_n_i),
         .i_trig  (w_trig),
         .o_irq   (w_irq)
      );
   end else begin : g_level
      logic r_irq;
      always_ff @(posedge ic_clk_i or negedge ic_rst_n_i) begin
         if (!ic_rst_n_i) begin
            r_irq <= 1'b0;
         end else begin
            r_irq <= |w_masked_next;
         end
      end
      assign w_irq = r_irq;
   end

   assign ic_rdata_o    = r_rdata;
   assign ic_rvalid_o   = r_rvalid;
   assign ic_irq_o      = w_irq;
   assign ic_overflow_o = r_ovf_any;

endmodule

// File: tb/tb_spi_ip_irq_ctrl.sv
// Directed bench: a LEVEL and a PULSE instance share stimulus; read data is
// checked against a scoreboard queue filled when each read is issued.
module tb_spi_ip_irq_ctrl;

   logic       clk;
   logic       rst_n;
   logic [3:0] ev;
   logic       wr_en;
   logic       rd_en;
   logic [1:0] addr;
   logic [3:0] wdata;

   logic [3:0] lvl_rdata, pul_rdata;
   logic       lvl_rvalid, pul_rvalid;
   logic       lvl_irq, pul_irq;
   logic       lvl_ovf, pul_ovf;

   int checks = 0;
   int errors = 0;
   logic [3:0] exp_q[$];

   spi_ip_irq_ctrl #(
      .PARAM_NUM_SRC (4), .PARAM_IRQ_MODE ("LEVEL"), .PARAM_HOLDOFF (8)
   ) u_lvl (
      .ic_clk_i (clk), .ic_rst_n_i (rst_n), .ic_event_i (ev),
      .ic_wr_en_i (wr_en), .ic_rd_en_i (rd_en), .ic_addr_i (addr),
      .ic_wdata_i (wdata), .ic_rdata_o (lvl_rdata), .ic_rvalid_o (lvl_rvalid),
      .ic_irq_o (lvl_irq), .ic_overflow_o (lvl_ovf)
   );

   spi_ip_irq_ctrl #(
      .PARAM_NUM_SRC (4), .PARAM_IRQ_MODE ("PULSE"), .PARAM_HOLDOFF (8)
   ) u_pul (
      .ic_clk_i (clk), .ic_rst_n_i (rst_n), .ic_event_i (ev),
      .ic_wr_en_i (wr_en), .ic_rd_en_i (rd_en), .ic_addr_i (addr),
      .ic_wdata_i (wdata), .ic_rdata_o (pul_rdata), .ic_rvalid_o (pul_rvalid),
      .ic_irq_o (pul_irq), .ic_overflow_o (pul_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic access(input logic rd, input logic wr, input logic [1:0] a,
                         input logic [3:0] wd, input logic [3:0] exp);
      rd_en = rd;
      wr_en = wr;
      addr  = a;
      wdata = wd;
      if (rd) exp_q.push_back(exp);
      step();
      rd_en = 1'b0;
      wr_en = 1'b0;
      wdata = '0;
   endtask

   // Read scoreboard: every rvalid must match the oldest outstanding read.
   always @(negedge clk) begin : rd_check
      logic [3:0] e;
      if (rst_n && (lvl_rvalid || pul_rvalid)) begin
         if (exp_q.size() == 0) begin
            chk("rd_spurious_rvalid", 32'(exp_q.size()), 32'd1);
         end else begin
            e = exp_q.pop_front();
            chk("rd_lvl_rdata", 32'(lvl_rdata), 32'(e));
            chk("rd_pul_rdata", 32'(pul_rdata), 32'(e));
            chk("rd_rvalid_both", 32'({lvl_rvalid, pul_rvalid}), 32'd3);
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      ev    = '0;
      wr_en = 1'b0;
      rd_en = 1'b0;
      addr  = '0;
      wdata = '0;

      // Reset state
      #3;
      chk("rst_lvl_irq",    32'(lvl_irq),    32'd0);
      chk("rst_pul_irq",    32'(pul_irq),    32'd0);
      chk("rst_rvalid",     32'({lvl_rvalid, pul_rvalid}), 32'd0);
      chk("rst_rdata",      32'(lvl_rdata),  32'd0);
      chk("rst_ovf",        32'({lvl_ovf, pul_ovf}), 32'd0);
      step(); step();
      rst_n = 1'b1;
      step();

      // Event 1: enabled event, level irq, readback, W1C
      access(1'b0, 1'b1, 2'd1, 4'b0001, 4'b0);
      ev = 4'b0001; step(); ev = '0;
      chk("e1_lvl_irq_rise", 32'(lvl_irq), 32'd1);
      chk("e1_pul_irq_rise", 32'(pul_irq), 32'd1);
      step();
      chk("e1_pul_width",    32'(pul_irq), 32'd0);
      chk("e1_lvl_irq_hold", 32'(lvl_irq), 32'd1);
      access(1'b1, 1'b0, 2'd0, 4'b0, 4'b0001);
      access(1'b0, 1'b1, 2'd0, 4'b0001, 4'b0);
      chk("e1_lvl_irq_clr", 32'(lvl_irq), 32'd0);
      for (int i = 0; i < 10; i++) begin
         step();
         chk("e1_pul_quiet", 32'(pul_irq), 32'd0);
      end

      // Event 2: double event -> overflow, then W1C
      ev = 4'b0100; step(); step(); ev = '0;
      chk("e2_lvl_ovf", 32'(lvl_ovf), 32'd1);
      chk("e2_pul_ovf", 32'(pul_ovf), 32'd1);
      chk("e2_lvl_irq_masked", 32'(lvl_irq), 32'd0);
      access(1'b1, 1'b0, 2'd2, 4'b0, 4'b0100);
      access(1'b0, 1'b1, 2'd2, 4'b0100, 4'b0);
      chk("e2_ovf_clr", 32'({lvl_ovf, pul_ovf}), 32'd0);
      access(1'b1, 1'b0, 2'd2, 4'b0, 4'b0000);

      // Event 3: set and clear in the same cycle on an already-pending bit
      ev = 4'b0010; step();
      access(1'b0, 1'b1, 2'd0, 4'b0010, 4'b0);
      ev = '0;
      access(1'b1, 1'b0, 2'd0, 4'b0, 4'b0110);
      access(1'b1, 1'b0, 2'd2, 4'b0, 4'b0000);
      chk("e3_no_ovf", 32'(lvl_ovf), 32'd0);

      // Simultaneous read and write returns the pre-write value; MASKED is read-only
      access(1'b1, 1'b1, 2'd0, 4'b0110, 4'b0110);
      access(1'b1, 1'b0, 2'd0, 4'b0, 4'b0000);
      access(1'b0, 1'b1, 2'd3, 4'b1111, 4'b0);
      access(1'b1, 1'b0, 2'd1, 4'b0, 4'b0001);
      access(1'b1, 1'b0, 2'd3, 4'b0, 4'b0000);

      // Event 5: pending while disabled, then enabled
      ev = 4'b1000; step(); ev = '0;
      chk("e5_lvl_irq_off", 32'(lvl_irq), 32'd0);
      chk("e5_pul_irq_off", 32'(pul_irq), 32'd0);
      access(1'b0, 1'b1, 2'd1, 4'b1000, 4'b0);
      chk("e5_lvl_irq_on", 32'(lvl_irq), 32'd1);
      chk("e5_pul_irq_on", 32'(pul_irq), 32'd1);
      step();
      chk("e5_pul_width", 32'(pul_irq), 32'd0);
      access(1'b1, 1'b0, 2'd3, 4'b0, 4'b1000);
      for (int i = 0; i < 10; i++) begin
         step();
         chk("e5_pul_single", 32'(pul_irq), 32'd0);
      end
      access(1'b0, 1'b1, 2'd0, 4'b1000, 4'b0);
      chk("e5_lvl_irq_clr", 32'(lvl_irq), 32'd0);

      // Event 4: holdoff coalescing; src0 at t, src1 at t+3, pulses at t+1 and t+9
      access(1'b0, 1'b1, 2'd1, 4'b0011, 4'b0);
      ev = 4'b0001; step(); ev = '0;
      chk("e4_pulse_t1", 32'(pul_irq), 32'd1);
      for (int k = 2; k <= 12; k++) begin
         step();
         chk($sformatf("e4_pulse_t%0d", k), 32'(pul_irq), (k == 9) ? 32'd1 : 32'd0);
         ev = (k == 3) ? 4'b0010 : 4'b0000;
      end
      ev = '0;
      access(1'b0, 1'b1, 2'd0, 4'b0011, 4'b0);
      for (int i = 0; i < 8; i++) step();

      // Event 6: reset asserted mid-HOLD with deferred pending and a read in flight
      ev = 4'b0001; step();
      chk("e6_pulse_first", 32'(pul_irq), 32'd1);
      ev = 4'b0010; step(); ev = '0;
      step();
      chk("e6_lvl_irq_pre", 32'(lvl_irq), 32'd1);
      rd_en = 1'b1;
      addr  = 2'd0;
      #2 rst_n = 1'b0;
      #1;
      chk("e6_rst_irq",    32'({lvl_irq, pul_irq}), 32'd0);
      chk("e6_rst_rvalid", 32'({lvl_rvalid, pul_rvalid}), 32'd0);
      chk("e6_rst_rdata",  32'({lvl_rdata, pul_rdata}), 32'd0);
      chk("e6_rst_ovf",    32'({lvl_ovf, pul_ovf}), 32'd0);
      step();
      chk("e6_rvalid_dropped", 32'({lvl_rvalid, pul_rvalid}), 32'd0);
      rd_en = 1'b0;
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step();
         chk("e6_no_pulse_after", 32'({lvl_irq, pul_irq}), 32'd0);
      end
      access(1'b1, 1'b0, 2'd1, 4'b0, 4'b0000);

      step(); step();
      chk("rd_queue_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
